// File: rtl/ex_wb_buf.sv
// Two-entry in-order buffer between the ALU stage and register writeback.
// Stored entries with a pending register write are forwarded to decode.

module ex_wb_buf #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      in_rd,
   input  logic            in_en,
   input  logic [XLEN-1:0] in_data,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            flush,
   output logic [4:0]      wb_rd,
   output logic            wb_en,
   output logic [XLEN-1:0] wb_data,
   output logic            wb_valid,
   input  logic            wb_ready,
   input  logic [4:0]      fwd_rs1_addr,
   input  logic [4:0]      fwd_rs2_addr,
   output logic            fwd_rs1_hit,
   output logic            fwd_rs2_hit,
   output logic [XLEN-1:0] fwd_rs1_data,
   output logic [XLEN-1:0] fwd_rs2_data,
   output logic [1:0]      count
);

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e          state_q;
   logic [4:0]      head_rd_q, tail_rd_q;
   logic            head_en_q, tail_en_q;
   logic [XLEN-1:0] head_data_q, tail_data_q;
   logic [1:0]      count_q;
   logic            in_ready_q;
   logic            wb_valid_q;

   logic push, pop, store_en;

   assign push     = in_valid && in_ready_q;
   assign pop      = wb_valid_q && wb_ready;
   // x0 is hardwired, so a write to it is stored as a bubble.
   assign store_en = in_en && (in_rd != 5'd0);

   // Head slot is always the oldest entry; slots are zeroed while unoccupied so
   // the writeback outputs read straight from the registers.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         state_q     <= StEmpty;
         head_rd_q   <= '0;
         head_en_q   <= 1'b0;
         head_data_q <= '0;
         tail_rd_q   <= '0;
         tail_en_q   <= 1'b0;
         tail_data_q <= '0;
         count_q     <= 2'd0;
         in_ready_q  <= 1'b1;
         wb_valid_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (push) begin
                  state_q     <= StOne;
                  head_rd_q   <= in_rd;
                  head_en_q   <= store_en;
                  head_data_q <= in_data;
                  count_q     <= 2'd1;
                  wb_valid_q  <= 1'b1;
               end
            end
            StOne: begin
               if (push && pop) begin
                  head_rd_q   <= in_rd;
                  head_en_q   <= store_en;
                  head_data_q <= in_data;
               end else if (push) begin
                  state_q     <= StFull;
                  tail_rd_q   <= in_rd;
                  tail_en_q   <= store_en;
                  tail_data_q <= in_data;
                  count_q     <= 2'd2;
                  in_ready_q  <= 1'b0;
               end else if (pop) begin
                  state_q     <= StEmpty;
                  head_rd_q   <= '0;
                  head_en_q   <= 1'b0;
                  head_data_q <= '0;
                  count_q     <= 2'd0;
                  wb_valid_q  <= 1'b0;
               end
            end
            StFull: begin
               if (pop) begin
                  state_q     <= StOne;
                  head_rd_q   <= tail_rd_q;
                  head_en_q   <= tail_en_q;
                  head_data_q <= tail_data_q;
                  tail_rd_q   <= '0;
                  tail_en_q   <= 1'b0;
                  tail_data_q <= '0;
                  count_q     <= 2'd1;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= StEmpty;
               head_rd_q   <= '0;
               head_en_q   <= 1'b0;
               head_data_q <= '0;
               tail_rd_q   <= '0;
               tail_en_q   <= 1'b0;
               tail_data_q <= '0;
               count_q     <= 2'd0;
               in_ready_q  <= 1'b1;
               wb_valid_q  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = in_ready_q;
   assign wb_valid = wb_valid_q;
   assign wb_rd    = head_rd_q;
   assign wb_en    = head_en_q;
   assign wb_data  = head_data_q;
   assign count    = count_q;

   logic head_live, tail_live;
   assign head_live = (state_q != StEmpty) && head_en_q;
   assign tail_live = (state_q == StFull) && tail_en_q;

   // Tail is the younger entry, so it wins when both slots match.
   always_comb begin
      fwd_rs1_hit  = 1'b0;
      fwd_rs1_data = '0;
      fwd_rs2_hit  = 1'b0;
      fwd_rs2_data = '0;
      if (fwd_rs1_addr != 5'd0) begin
         if (tail_live && (tail_rd_q == fwd_rs1_addr)) begin
            fwd_rs1_hit  = 1'b1;
            fwd_rs1_data = tail_data_q;
         end else if (head_live && (head_rd_q == fwd_rs1_addr)) begin
            fwd_rs1_hit  = 1'b1;
            fwd_rs1_data = head_data_q;
         end
      end
      if (fwd_rs2_addr != 5'd0) begin
         if (tail_live && (tail_rd_q == fwd_rs2_addr)) begin
            fwd_rs2_hit  = 1'b1;
            fwd_rs2_data = tail_data_q;
         end else if (head_live && (head_rd_q == fwd_rs2_addr)) begin
            fwd_rs2_hit  = 1'b1;
            fwd_rs2_data = head_data_q;
         end
      end
   end

endmodule

// File: tb/tb_ex_wb_buf.sv
// Directed bench for ex_wb_buf: ordering, backpressure, forwarding, flush and reset.

module tb_ex_wb_buf;

   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [4:0]      in_rd;
   logic            in_en;
   logic [XLEN-1:0] in_data;
   logic            in_valid;
   logic            in_ready;
   logic            flush;
   logic [4:0]      wb_rd;
   logic            wb_en;
   logic [XLEN-1:0] wb_data;
   logic            wb_valid;
   logic            wb_ready;
   logic [4:0]      fwd_rs1_addr, fwd_rs2_addr;
   logic            fwd_rs1_hit, fwd_rs2_hit;
   logic [XLEN-1:0] fwd_rs1_data, fwd_rs2_data;
   logic [1:0]      count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_wb_buf #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .in_rd(in_rd), .in_en(in_en), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .flush(flush),
      .wb_rd(wb_rd), .wb_en(wb_en), .wb_data(wb_data), .wb_valid(wb_valid),
      .wb_ready(wb_ready),
      .fwd_rs1_addr(fwd_rs1_addr), .fwd_rs2_addr(fwd_rs2_addr),
      .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
      .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
      .count(count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic en,
                        input logic [XLEN-1:0] d);
      in_valid = v;
      in_rd    = rd;
      in_en    = en;
      in_data  = d;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; wb_ready = 1'b0;
      drive(1'b0, 5'd0, 1'b0, '0);
      fwd_rs1_addr = 5'd0; fwd_rs2_addr = 5'd0;
      step();
      rst = 1'b1;
      #1;
      chk("rst_count", count, 2'd0);
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_wb_data", wb_data, 32'h0);

      // Single pass
      wb_ready = 1'b1;
      drive(1'b1, 5'd5, 1'b1, 32'h1234);
      step();
      drive(1'b0, 5'd0, 1'b0, '0);
      chk("pass_valid", wb_valid, 1'b1);
      chk("pass_rd", wb_rd, 5'd5);
      chk("pass_en", wb_en, 1'b1);
      chk("pass_data", wb_data, 32'h1234);
      chk("pass_count", count, 2'd1);
      step();
      chk("pass_empty_count", count, 2'd0);
      chk("pass_empty_valid", wb_valid, 1'b0);
      chk("pass_empty_data", wb_data, 32'h0);

      // Backpressure and ordering
      wb_ready = 1'b0;
      drive(1'b1, 5'd1, 1'b1, 32'h11);
      step();
      drive(1'b1, 5'd2, 1'b1, 32'h22);
      step();
      chk("bp_count_full", count, 2'd2);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_head_rd", wb_rd, 5'd1);
      drive(1'b1, 5'd7, 1'b1, 32'h77);
      step();
      chk("bp_third_ignored", count, 2'd2);
      chk("bp_head_stable", wb_data, 32'h11);
      drive(1'b0, 5'd0, 1'b0, '0);
      wb_ready = 1'b1;
      step();
      chk("bp_second_data", wb_data, 32'h22);
      chk("bp_second_rd", wb_rd, 5'd2);
      chk("bp_count_one", count, 2'd1);
      chk("bp_in_ready_back", in_ready, 1'b1);
      step();
      chk("bp_drained", count, 2'd0);

      // Forward priority, then flush while full
      wb_ready = 1'b0;
      drive(1'b1, 5'd3, 1'b1, 32'hAA);
      step();
      drive(1'b1, 5'd3, 1'b1, 32'hBB);
      step();
      drive(1'b1, 5'd9, 1'b1, 32'h99);
      fwd_rs1_addr = 5'd3; fwd_rs2_addr = 5'd0;
      #1;
      chk("fwd_rs1_hit", fwd_rs1_hit, 1'b1);
      chk("fwd_rs1_young", fwd_rs1_data, 32'hBB);
      chk("fwd_rs2_x0_hit", fwd_rs2_hit, 1'b0);
      chk("fwd_rs2_x0_data", fwd_rs2_data, 32'h0);
      fwd_rs2_addr = 5'd9;
      #1;
      chk("fwd_ignores_input", fwd_rs2_hit, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, 5'd0, 1'b0, '0);
      chk("flush_count", count, 2'd0);
      chk("flush_valid", wb_valid, 1'b0);
      chk("flush_fwd", fwd_rs1_hit, 1'b0);

      // x0 writes and bubbles
      drive(1'b1, 5'd0, 1'b1, 32'h55);
      step();
      chk("x0_valid", wb_valid, 1'b1);
      chk("x0_en", wb_en, 1'b0);
      chk("x0_data", wb_data, 32'h55);
      fwd_rs1_addr = 5'd0;
      drive(1'b1, 5'd4, 1'b0, 32'h44);
      step();
      drive(1'b0, 5'd0, 1'b0, '0);
      fwd_rs1_addr = 5'd4;
      #1;
      chk("bubble_count", count, 2'd2);
      chk("bubble_fwd_hit", fwd_rs1_hit, 1'b0);
      wb_ready = 1'b1;
      step();
      chk("bubble_head_rd", wb_rd, 5'd4);
      chk("bubble_head_en", wb_en, 1'b0);
      chk("bubble_head_data", wb_data, 32'h44);
      step();
      chk("bubble_drained", count, 2'd0);

      // Simultaneous push and pop with one entry
      wb_ready = 1'b0;
      drive(1'b1, 5'd8, 1'b1, 32'h88);
      step();
      fwd_rs2_addr = 5'd8;
      #1;
      chk("one_fwd_hit", fwd_rs2_hit, 1'b1);
      chk("one_fwd_data", fwd_rs2_data, 32'h88);
      drive(1'b1, 5'd9, 1'b1, 32'h99);
      wb_ready = 1'b1;
      step();
      chk("pp_count", count, 2'd1);
      chk("pp_head_rd", wb_rd, 5'd9);
      chk("pp_head_data", wb_data, 32'h99);

      // Reset while full overrides push and pop
      wb_ready = 1'b0;
      drive(1'b1, 5'd10, 1'b1, 32'hA0);
      step();
      chk("rf_count_full", count, 2'd2);
      rst = 1'b0; wb_ready = 1'b1; flush = 1'b1;
      drive(1'b1, 5'd11, 1'b1, 32'hB0);
      step();
      rst = 1'b1; wb_ready = 1'b0; flush = 1'b0;
      drive(1'b0, 5'd0, 1'b0, '0);
      fwd_rs1_addr = 5'd9; fwd_rs2_addr = 5'd10;
      #1;
      chk("rf_count", count, 2'd0);
      chk("rf_valid", wb_valid, 1'b0);
      chk("rf_rd", wb_rd, 5'd0);
      chk("rf_en", wb_en, 1'b0);
      chk("rf_data", wb_data, 32'h0);
      chk("rf_in_ready", in_ready, 1'b1);
      chk("rf_fwd1_hit", fwd_rs1_hit, 1'b0);
      chk("rf_fwd2_hit", fwd_rs2_hit, 1'b0);
      chk("rf_fwd1_data", fwd_rs1_data, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_wb_buf.md
EX_WB_BUF -- requirements
Module: ex_wb_buf

Interface
REQ-001 SHALL have parameter XLEN, default 32 (`MAX_BIT_POS+1), data path width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low (rst=0 resets on next clk edge; rst=1 runs).
REQ-004 SHALL have port in_rd  input  5  destination register from ALU stage (rd_out).
REQ-005 SHALL have port in_en  input  1  write enable from ALU stage (out_en).
REQ-006 SHALL have port in_data  input  XLEN  result from ALU stage (rd_data).
REQ-007 SHALL have port in_valid  input  1  upstream result valid this cycle.
REQ-008 SHALL have port in_ready  output  1  buffer can accept this cycle.
REQ-009 SHALL have port flush  input  1  discard all buffered entries.
REQ-010 SHALL have port wb_rd  output  5  head-entry destination register.
REQ-011 SHALL have port wb_en  output  1  head-entry write enable.
REQ-012 SHALL have port wb_data  output  XLEN  head-entry data.
REQ-013 SHALL have port wb_valid  output  1  head entry present.
REQ-014 SHALL have port wb_ready  input  1  writeback consumes head this cycle.
REQ-015 SHALL have ports fwd_rs1_addr, fwd_rs2_addr  input  5 each  source registers being read in decode.
REQ-016 SHALL have ports fwd_rs1_hit, fwd_rs2_hit  output  1 each  buffered pending write matches address.
REQ-017 SHALL have ports fwd_rs1_data, fwd_rs2_data  output  XLEN each  forwarded value.
REQ-018 SHALL have port count  output  2  occupancy 0..2.

Function
REQ-019 SHALL be a 2-entry in-order FIFO, states EMPTY (count 0), ONE (1), FULL (2).
REQ-020 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL, independent of wb_ready (no combinational ready path).
REQ-021 SHALL push when in_valid && in_ready; pop when wb_valid && wb_ready.
REQ-022 SHALL store en forced to 0 when in_rd == 0 (x0 never written); data stored unchanged.
REQ-023 SHALL accept entries with in_en=0 (bubbles) and present them with wb_en=0, popped normally.
REQ-024 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE (new entry becomes head); FULL+pop->ONE; otherwise hold.
REQ-025 SHALL give 1-cycle latency: push at edge N makes wb_valid=1 with that entry from cycle N+1 when previously EMPTY.
REQ-026 SHALL drive wb_rd/wb_en/wb_data from head entry when wb_valid=1, and all zero when EMPTY.
REQ-027 SHALL hold head outputs stable while wb_valid && !wb_ready.
REQ-028 flush=1 SHALL set state EMPTY at the next edge, overriding any push or pop in the same cycle.
REQ-029 Forwarding: fwd_rsN_hit = 1 iff fwd_rsN_addr != 0 and some valid entry has en=1 and rd == addr; combinational from current state.
REQ-030 On multiple matches, fwd_rsN_data SHALL take the youngest (tail) entry; with no hit, fwd_rsN_data = 0.
REQ-031 Forwarding SHALL ignore the in_* inputs in the current cycle (only stored entries).
REQ-032 count SHALL equal the number of valid entries.

Reset
REQ-033 rst=0 at an edge SHALL set state EMPTY, count=0, wb_valid=0, wb_rd=0, wb_en=0, wb_data=0, in_ready=1, both fwd hits 0 and data 0.
REQ-034 Reset SHALL override flush, push and pop in the same cycle; entries in flight are discarded.

Verification
REQ-035 Single pass: EMPTY, push rd=5 en=1 data=0x1234 with wb_ready=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234; following cycle EMPTY.
REQ-036 Backpressure: wb_ready=0, push A(rd=1,0x11), B(rd=2,0x22) -> count=2, in_ready=0, third push ignored; wb_ready=1 -> A then B, in order.
REQ-037 Forward priority: buffer holds A(rd=3,0xAA) then B(rd=3,0xBB), fwd_rs1_addr=3 -> hit=1, data=0xBB; fwd_rs2_addr=0 -> hit=0, data=0.
REQ-038 x0 and bubbles: push rd=0 en=1 data=0x55 -> wb_en=0, fwd addr 0 never hits; push en=0 rd=4 -> wb_en=0, fwd addr 4 hit=0.
REQ-039 Simultaneous push/pop in ONE: head A, push C, wb_ready=1 -> count stays 1, head becomes C next cycle.
REQ-040 Flush/reset: FULL, flush=1 with in_valid=1 -> next cycle count=0, wb_valid=0; FULL, rst=0 -> next cycle all outputs zero, in_ready=1.
